// File: rtl/soc_bus_xbar.sv
// soc_bus_xbar: N-master / M-slave address-decoded request/grant crossbar with
// per-slave round-robin arbitration and in-order response routing back to masters.
module soc_bus_xbar #(
    parameter int NB_MASTER       = 3,
    parameter int NB_SLAVE        = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR =
        {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR =
        {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF}
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NB_MASTER-1:0]                m_req_i,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NB_MASTER-1:0]                m_we_i,
    input  logic [NB_MASTER*DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]     m_wdata_i,
    output logic [NB_MASTER-1:0]                m_gnt_o,
    output logic [NB_MASTER-1:0]                m_rvalid_o,
    output logic [NB_MASTER*DATA_WIDTH-1:0]     m_rdata_o,
    output logic [NB_MASTER-1:0]                m_err_o,
    output logic [NB_SLAVE-1:0]                 s_req_o,
    output logic [NB_SLAVE*ADDR_WIDTH-1:0]      s_addr_o,
    output logic [NB_SLAVE-1:0]                 s_we_o,
    output logic [NB_SLAVE*DATA_WIDTH/8-1:0]    s_be_o,
    output logic [NB_SLAVE*DATA_WIDTH-1:0]      s_wdata_o,
    input  logic [NB_SLAVE-1:0]                 s_gnt_i,
    input  logic [NB_SLAVE-1:0]                 s_rvalid_i,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]      s_rdata_i
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int SW = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [NB_MASTER-1:0] outstanding_r;
    logic [NB_MASTER-1:0] err_valid_r;
    logic [MW-1:0]        rr_ptr_r [NB_SLAVE];
    logic [MW-1:0]        fifo_r   [NB_SLAVE][MAX_OUTSTANDING];
    logic [PW-1:0]        wr_ptr_r [NB_SLAVE];
    logic [PW-1:0]        rd_ptr_r [NB_SLAVE];
    logic [CW-1:0]        count_r  [NB_SLAVE];

    logic [NB_MASTER-1:0] elig_s;
    logic [NB_MASTER-1:0] dec_hit_s;
    logic [SW-1:0]        dec_slave_s [NB_MASTER];
    logic [MW-1:0]        win_idx_s   [NB_SLAVE];
    logic [MW-1:0]        head_s      [NB_SLAVE];
    logic [NB_SLAVE-1:0]  win_found_s;
    logic [NB_SLAVE-1:0]  fifo_full_s;
    logic [NB_SLAVE-1:0]  push_s;
    logic [NB_SLAVE-1:0]  pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        ptr_inc = (int'(ptr) == MAX_OUTSTANDING - 1) ? {PW{1'b0}} : ptr + PW'(1);
    endfunction

    // A master may only hold one transaction; nothing is eligible during reset
    assign elig_s = rst ? {NB_MASTER{1'b0}} : (m_req_i & ~outstanding_r);

    // Address decode: scanning from the top lets the lowest matching window win
    always_comb begin
        logic win;
        win = 1'b0;
        for (int i = 0; i < NB_MASTER; i++) begin
            dec_hit_s[i]   = 1'b0;
            dec_slave_s[i] = {SW{1'b0}};
            for (int k = NB_SLAVE - 1; k >= 0; k--) begin
                win = (m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
                      (m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]);
                dec_hit_s[i]   = dec_hit_s[i] | win;
                dec_slave_s[i] = win ? SW'(k) : dec_slave_s[i];
            end
        end
    end

    // Per-slave round-robin search starting at the slave's pointer
    always_comb begin
        logic [MW-1:0] idx;
        idx = {MW{1'b0}};
        for (int k = 0; k < NB_SLAVE; k++) begin
            win_found_s[k] = 1'b0;
            win_idx_s[k]   = {MW{1'b0}};
            fifo_full_s[k] = (int'(count_r[k]) >= MAX_OUTSTANDING);
            for (int off = 0; off < NB_MASTER; off++) begin
                idx = MW'((int'(rr_ptr_r[k]) + off) % NB_MASTER);
                if (!win_found_s[k] && elig_s[idx] && dec_hit_s[idx] &&
                    (int'(dec_slave_s[idx]) == k)) begin
                    win_found_s[k] = 1'b1;
                    win_idx_s[k]   = idx;
                end else begin
                    win_found_s[k] = win_found_s[k];
                end
            end
        end
    end

    // Forward each winner to its slave port; a full tracking FIFO holds the request back
    always_comb begin
        for (int k = 0; k < NB_SLAVE; k++) begin
            s_req_o[k] = win_found_s[k] && !fifo_full_s[k];
            push_s[k]  = s_req_o[k] && s_gnt_i[k];
            pop_s[k]   = !rst && s_rvalid_i[k] && (count_r[k] != {CW{1'b0}});
            head_s[k]  = fifo_r[k][rd_ptr_r[k]];
            if (s_req_o[k]) begin
                s_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr_i[int'(win_idx_s[k])*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o[k]                             = m_we_i[win_idx_s[k]];
                s_be_o[k*BW +: BW]                    = m_be_i[int'(win_idx_s[k])*BW +: BW];
                s_wdata_o[k*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[int'(win_idx_s[k])*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                s_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH]  = {ADDR_WIDTH{1'b0}};
                s_we_o[k]                             = 1'b0;
                s_be_o[k*BW +: BW]                    = {BW{1'b0}};
                s_wdata_o[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
    end

    // Grants and responses; a master has at most one source responding at a time, so OR-merging is safe
    always_comb begin
        m_gnt_o    = elig_s & ~dec_hit_s;
        m_rvalid_o = rst ? {NB_MASTER{1'b0}} : err_valid_r;
        m_err_o    = rst ? {NB_MASTER{1'b0}} : err_valid_r;
        m_rdata_o  = {(NB_MASTER*DATA_WIDTH){1'b0}};
        for (int k = 0; k < NB_SLAVE; k++) begin
            m_gnt_o[win_idx_s[k]]  = m_gnt_o[win_idx_s[k]] | push_s[k];
            m_rvalid_o[head_s[k]]  = m_rvalid_o[head_s[k]] | pop_s[k];
            m_rdata_o[int'(head_s[k])*DATA_WIDTH +: DATA_WIDTH] =
                m_rdata_o[int'(head_s[k])*DATA_WIDTH +: DATA_WIDTH] |
                (s_rdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{pop_s[k]}});
        end
    end

    // Transaction tracking: outstanding flags, error-response slots, FIFOs, round-robin pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= {NB_MASTER{1'b0}};
            err_valid_r   <= {NB_MASTER{1'b0}};
            for (int k = 0; k < NB_SLAVE; k++) begin
                rr_ptr_r[k] <= {MW{1'b0}};
                wr_ptr_r[k] <= {PW{1'b0}};
                rd_ptr_r[k] <= {PW{1'b0}};
                count_r[k]  <= {CW{1'b0}};
                for (int d = 0; d < MAX_OUTSTANDING; d++) begin
                    fifo_r[k][d] <= {MW{1'b0}};
                end
            end
        end else begin
            outstanding_r <= (outstanding_r & ~m_rvalid_o) | m_gnt_o;
            err_valid_r   <= elig_s & ~dec_hit_s;
            for (int k = 0; k < NB_SLAVE; k++) begin
                if (push_s[k]) begin
                    fifo_r[k][wr_ptr_r[k]] <= win_idx_s[k];
                    wr_ptr_r[k]            <= ptr_inc(wr_ptr_r[k]);
                    rr_ptr_r[k]            <= MW'((int'(win_idx_s[k]) + 1) % NB_MASTER);
                end else begin
                    wr_ptr_r[k] <= wr_ptr_r[k];
                    rr_ptr_r[k] <= rr_ptr_r[k];
                end
                if (pop_s[k]) begin
                    rd_ptr_r[k] <= ptr_inc(rd_ptr_r[k]);
                end else begin
                    rd_ptr_r[k] <= rd_ptr_r[k];
                end
                case ({push_s[k], pop_s[k]})
                    2'b10:   count_r[k] <= count_r[k] + CW'(1);
                    2'b01:   count_r[k] <= count_r[k] - CW'(1);
                    default: count_r[k] <= count_r[k];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_soc_bus_xbar.sv
// Directed bench for soc_bus_xbar (3x3, default map) with a queue-based reference model
// compared on every falling edge plus hand-computed literal expectations.
module tb_soc_bus_xbar;

    logic        clk;
    logic        rst;
    logic [2:0]  m_req_i, m_we_i, m_gnt_o, m_rvalid_o, m_err_o;
    logic [95:0] m_addr_i, m_wdata_i, m_rdata_o;
    logic [11:0] m_be_i;
    logic [2:0]  s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
    logic [95:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [11:0] s_be_o;

    int checks;
    int failures;

    soc_bus_xbar dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] WIN_LO [3] = '{32'h0000_0000, 32'h0010_0000, 32'h1A10_0000};
    localparam logic [31:0] WIN_HI [3] = '{32'h000F_FFFF, 32'h0FFF_FFFF, 32'h1A11_FFFF};

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < 3; k++) begin
            if (a >= WIN_LO[k] && a <= WIN_HI[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: per-slave queues of issuing masters, busy flags, pending error replies
    int mq [3][$];
    bit busy [3];
    bit errp [3];
    int rr [3];

    always @(negedge clk) begin
        int dec [3];
        int w [3];
        int h;
        logic [2:0]  e_gnt, e_rv, e_err, e_sreq, e_swe;
        logic [95:0] e_rdata, e_saddr, e_swdata;
        logic [11:0] e_sbe;
        e_gnt = 3'b000; e_rv = 3'b000; e_err = 3'b000; e_sreq = 3'b000; e_swe = 3'b000;
        e_rdata = 96'h0; e_saddr = 96'h0; e_swdata = 96'h0; e_sbe = 12'h000;
        for (int i = 0; i < 3; i++) begin
            dec[i] = decode(m_addr_i[i*32 +: 32]);
            w[i]   = -1;
        end
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (mq[k].size() < 2) begin
                    for (int off = 0; off < 3; off++) begin
                        h = (rr[k] + off) % 3;
                        if (w[k] < 0 && m_req_i[h] && !busy[h] && dec[h] == k) w[k] = h;
                    end
                end
                if (w[k] >= 0) begin
                    e_sreq[k]          = 1'b1;
                    e_saddr[k*32 +: 32]  = m_addr_i[w[k]*32 +: 32];
                    e_swe[k]           = m_we_i[w[k]];
                    e_sbe[k*4 +: 4]    = m_be_i[w[k]*4 +: 4];
                    e_swdata[k*32 +: 32] = m_wdata_i[w[k]*32 +: 32];
                    if (s_gnt_i[k]) e_gnt[w[k]] = 1'b1;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (m_req_i[i] && !busy[i] && dec[i] < 0) e_gnt[i] = 1'b1;
                if (errp[i]) begin
                    e_rv[i]  = 1'b1;
                    e_err[i] = 1'b1;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (s_rvalid_i[k] && mq[k].size() > 0) begin
                    h = mq[k][0];
                    e_rv[h] = 1'b1;
                    e_rdata[h*32 +: 32] = s_rdata_i[k*32 +: 32];
                end
            end
        end
        chk("m_gnt_o", m_gnt_o, e_gnt);
        chk("m_rvalid_o", m_rvalid_o, e_rv);
        chk("m_err_o", m_err_o, e_err);
        chk("m_rdata_o", m_rdata_o, e_rdata);
        chk("s_req_o", s_req_o, e_sreq);
        chk("s_addr_o", s_addr_o, e_saddr);
        chk("s_we_o", s_we_o, e_swe);
        chk("s_be_o", s_be_o, e_sbe);
        chk("s_wdata_o", s_wdata_o, e_swdata);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                busy[k] = 1'b0;
                errp[k] = 1'b0;
                rr[k]   = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (s_rvalid_i[k] && mq[k].size() > 0) begin
                    busy[mq[k][0]] = 1'b0;
                    void'(mq[k].pop_front());
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (errp[i]) busy[i] = 1'b0;
                errp[i] = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (w[k] >= 0 && s_gnt_i[k]) begin
                    mq[k].push_back(w[k]);
                    busy[w[k]] = 1'b1;
                    rr[k] = (w[k] + 1) % 3;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (e_gnt[i] && dec[i] < 0) begin
                    errp[i] = 1'b1;
                    busy[i] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        m_req_i    = 3'b000;
        s_gnt_i    = 3'b000;
        s_rvalid_i = 3'b000;
    endtask

    task automatic req(input int i, input logic [31:0] a);
        m_req_i[i]       = 1'b1;
        m_addr_i[i*32 +: 32] = a;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        m_we_i     = 3'b010;
        m_be_i     = {4'hC, 4'h3, 4'hF};
        m_wdata_i  = {32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        m_addr_i   = {32'h0000_0300, 32'h0010_0200, 32'h0000_0100};
        s_rdata_i  = 96'h0;
        idle();
        m_req_i    = 3'b111;
        s_gnt_i    = 3'b111;

        // reset holds everything quiet even with requests present
        step(); step(); settle();
        chk("rst_gnt", m_gnt_o, 3'b000);
        chk("rst_sreq", s_req_o, 3'b000);
        chk("rst_rvalid", m_rvalid_o, 3'b000);
        step(); rst = 1'b0; idle();

        // single read through slave 1
        step(); req(0, 32'h0010_0040); s_gnt_i = 3'b010; settle();
        chk("t1_sreq", s_req_o, 3'b010);
        chk("t1_gnt", m_gnt_o, 3'b001);
        chk("t1_saddr", s_addr_o[63:32], 32'h0010_0040);
        step(); idle(); settle();
        chk("t1_c1_rvalid", m_rvalid_o, 3'b000);
        step(); s_rvalid_i = 3'b010; s_rdata_i[63:32] = 32'hDEAD_BEEF; settle();
        chk("t1_rvalid", m_rvalid_o, 3'b001);
        chk("t1_rdata", m_rdata_o[31:0], 32'hDEAD_BEEF);
        chk("t1_err", m_err_o, 3'b000);
        step(); idle();

        // round robin on slave 0 with FIFO depth 2
        step(); req(0, 32'h0000_1000); req(1, 32'h0000_2000); req(2, 32'h000F_FFFF);
        s_gnt_i = 3'b001; settle();
        chk("t2_gnt0", m_gnt_o, 3'b001);
        step(); settle();
        chk("t2_gnt1", m_gnt_o, 3'b010);
        chk("t2_saddr1", s_addr_o[31:0], 32'h0000_2000);
        step(); s_rvalid_i = 3'b001; s_rdata_i[31:0] = 32'h1111_0000; settle();
        chk("t2_full_gnt", m_gnt_o, 3'b000);
        chk("t2_full_rv", m_rvalid_o, 3'b001);
        step(); s_rvalid_i = 3'b000; settle();
        chk("t2_gnt2", m_gnt_o, 3'b100);
        step(); m_req_i = 3'b000; s_rvalid_i = 3'b001; s_rdata_i[31:0] = 32'h1111_0001; settle();
        chk("t2_rv1", m_rvalid_o, 3'b010);
        chk("t2_rd1", m_rdata_o[63:32], 32'h1111_0001);
        step(); s_rdata_i[31:0] = 32'h1111_0002; settle();
        chk("t2_rv2", m_rvalid_o, 3'b100);
        step(); idle(); req(0, 32'h0000_1000); req(1, 32'h0000_2000); s_gnt_i = 3'b001; settle();
        chk("t2_wrap", m_gnt_o, 3'b001);
        step(); idle(); s_rvalid_i = 3'b001; settle();
        step(); idle();

        // decode error on master 2
        s_rdata_i = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        step(); req(2, 32'h2000_0000); s_gnt_i = 3'b111; settle();
        chk("t3_gnt", m_gnt_o, 3'b100);
        chk("t3_sreq", s_req_o, 3'b000);
        step(); settle();
        chk("t3_rvalid", m_rvalid_o, 3'b100);
        chk("t3_err", m_err_o, 3'b100);
        chk("t3_rdata", m_rdata_o[95:64], 32'h0000_0000);
        chk("t3_busy_gnt", m_gnt_o, 3'b000);
        step(); idle(); settle();
        chk("t3_done", m_rvalid_o, 3'b000);

        // slave 2 FIFO fills, third request waits for the first response
        step(); req(0, 32'h1A10_0010); req(1, 32'h1A11_FFFF); s_gnt_i = 3'b100; settle();
        chk("t4_gnt0", m_gnt_o, 3'b001);
        step(); m_req_i[0] = 1'b0; settle();
        chk("t4_gnt1", m_gnt_o, 3'b010);
        step(); m_req_i[1] = 1'b0; req(2, 32'h1A10_0000); settle();
        chk("t4_masked", s_req_o, 3'b000);
        chk("t4_nogrant", m_gnt_o, 3'b000);
        step(); s_rvalid_i = 3'b100; s_rdata_i[95:64] = 32'h3333_0000; settle();
        chk("t4_rv0", m_rvalid_o, 3'b001);
        chk("t4_still_masked", s_req_o, 3'b000);
        step(); s_rvalid_i = 3'b000; settle();
        chk("t4_sreq", s_req_o, 3'b100);
        chk("t4_gnt2", m_gnt_o, 3'b100);
        step(); m_req_i = 3'b000; s_rvalid_i = 3'b100; s_rdata_i[95:64] = 32'h3333_0001; settle();
        chk("t4_rv1", m_rvalid_o, 3'b010);
        step(); s_rdata_i[95:64] = 32'h3333_0002; settle();
        chk("t4_rv2", m_rvalid_o, 3'b100);
        step(); idle();

        // simultaneous push and pop on slave 0
        step(); req(0, 32'h0000_0100); s_gnt_i = 3'b001; settle();
        chk("t5_gnt0", m_gnt_o, 3'b001);
        step(); m_req_i[0] = 1'b0; req(1, 32'h0000_0200); s_rvalid_i = 3'b001;
        s_rdata_i[31:0] = 32'hAAAA_0000; settle();
        chk("t5_rv0", m_rvalid_o, 3'b001);
        chk("t5_rd0", m_rdata_o[31:0], 32'hAAAA_0000);
        chk("t5_gnt1", m_gnt_o, 3'b010);
        step(); m_req_i = 3'b000; s_rdata_i[31:0] = 32'hBBBB_0001; settle();
        chk("t5_rv1", m_rvalid_o, 3'b010);
        chk("t5_rd1", m_rdata_o[63:32], 32'hBBBB_0001);
        step(); idle(); s_rvalid_i = 3'b111; settle();
        chk("t5_drop", m_rvalid_o, 3'b000);

        // reset with two transactions outstanding on slave 1
        step(); idle(); req(0, 32'h0010_0000); req(1, 32'h0FFF_FFFF); s_gnt_i = 3'b010; settle();
        chk("t6_gnt1", m_gnt_o, 3'b010);
        step(); settle();
        chk("t6_gnt0", m_gnt_o, 3'b001);
        step(); rst = 1'b1; idle(); settle();
        chk("t6_rst_rv", m_rvalid_o, 3'b000);
        step(); rst = 1'b0; s_rvalid_i = 3'b010; s_rdata_i[63:32] = 32'h5555_5555; settle();
        chk("t6_drop_rv", m_rvalid_o, 3'b000);
        chk("t6_drop_rd", m_rdata_o, 96'h0);
        chk("t6_sreq", s_req_o, 3'b000);
        step(); idle(); req(1, 32'h0010_0004); s_gnt_i = 3'b010; settle();
        chk("t6_regrant", m_gnt_o, 3'b010);
        step(); idle(); s_rvalid_i = 3'b010; settle();
        chk("t6_resp", m_rvalid_o, 3'b010);
        step(); idle();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
